// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-cycle multiply/divide plus mthi/mtlo for the EX stage.
// Drives the HI/LO write bus consumed by decode and a pipeline stall request.
module hilo_muldiv_unit #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [2:0]      op_code,
    input  logic [DW-1:0]   src_a,
    input  logic [DW-1:0]   src_b,
    input  logic            flush,
    output logic [2*DW+1:0] ex_hilo,
    output logic            stallreq,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_n;

    logic [2*DW-1:0] acc;
    logic [DW-1:0]   opd;
    logic [DW-1:0]   a_raw;
    logic [4:0]      cnt;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;
    logic            b_zero;

    logic            start;
    logic            stall_c;
    logic            hi_we;
    logic            lo_we;
    logic [DW-1:0]   hi_wd;
    logic [DW-1:0]   lo_wd;

    logic            op_signed;
    logic            op_isdiv;
    logic            sgn_a;
    logic            sgn_b;
    logic [DW-1:0]   mag_a;
    logic [DW-1:0]   mag_b;

    assign op_signed = ~op_code[0];
    assign op_isdiv  = op_code[1];
    assign sgn_a     = op_signed & src_a[DW-1];
    assign sgn_b     = op_signed & src_b[DW-1];
    assign mag_a     = sgn_a ? -src_a : src_a;
    assign mag_b     = sgn_b ? -src_b : src_b;

    // One shift-add / restoring-subtract step per BUSY cycle
    logic [DW:0]     sum;
    logic [DW:0]     rem_sh;
    logic            ge;
    logic [DW-1:0]   diff;
    logic [2*DW-1:0] acc_step;

    always_comb begin
        sum    = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opd} : '0);
        rem_sh = acc[2*DW-1:DW-1];
        ge     = rem_sh >= {1'b0, opd};
        diff   = rem_sh[DW-1:0] - opd;
        if (is_div)
            acc_step = {ge ? diff : rem_sh[DW-1:0], acc[DW-2:0], ge};
        else
            acc_step = {sum, acc[DW-1:1]};
    end

    logic [2*DW-1:0] prod;
    logic [DW-1:0]   quot;
    logic [DW-1:0]   rem;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quot = b_zero ? '1 : (neg_q ? -acc[DW-1:0] : acc[DW-1:0]);
        rem  = b_zero ? a_raw
                      : (neg_r ? -acc[2*DW-1:DW] : acc[2*DW-1:DW]);
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        stall_c = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        hi_wd   = '0;
        lo_wd   = '0;
        unique case (state)
            IDLE: begin
                if (op_valid && !flush) begin
                    unique case (1'b1)
                        (op_code <= 3'd3): begin
                            start   = 1'b1;
                            stall_c = 1'b1;
                            state_n = BUSY;
                        end
                        (op_code == 3'd4): begin
                            hi_we = 1'b1;
                            hi_wd = src_a;
                        end
                        (op_code == 3'd5): begin
                            lo_we = 1'b1;
                            lo_wd = src_a;
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (flush) begin
                    state_n = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (cnt == 5'd31)
                        state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                if (!flush) begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    if (is_div) begin
                        hi_wd = rem;
                        lo_wd = quot;
                    end else begin
                        hi_wd = prod[2*DW-1:DW];
                        lo_wd = prod[DW-1:0];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            opd    <= '0;
            a_raw  <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (start) begin
            acc    <= {{DW{1'b0}}, op_isdiv ? mag_a : mag_b};
            opd    <= op_isdiv ? mag_b : mag_a;
            a_raw  <= src_a;
            cnt    <= '0;
            is_div <= op_isdiv;
            neg_q  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            b_zero <= (src_b == '0);
        end else if (state == BUSY) begin
            acc <= acc_step;
            cnt <= cnt + 5'd1;
        end
    end

    // Outputs go quiet the instant reset is asserted
    assign ex_hilo  = rst_n ? {hi_we, lo_we, hi_wd, lo_wd} : '0;
    assign stallreq = rst_n & stall_c;
    assign busy     = (state != IDLE);

endmodule
